// File: rtl/out_port_uart_tx_if.sv
// Core-side OUT port: push request/data from the core, full back-pressure to it.
interface out_port_uart_tx_if;
    logic        out_en;
    logic [15:0] out_data;
    logic        out_stall;

    modport master (
        output out_en,
        output out_data,
        input  out_stall
    );

    modport slave (
        input  out_en,
        input  out_data,
        output out_stall
    );
endinterface

// File: rtl/out_port_uart_tx.sv
// OUT instruction responder: buffers 16-bit words in a FIFO and sends each
// word as two 8N1 UART bytes, high byte first.
module out_port_uart_tx #(
    parameter int  DEPTH        = 8,
    parameter int  CLKS_PER_BIT = 434,
    localparam int CW           = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    out_port_uart_tx_if.slave   core,
    output logic                tx,
    output logic                busy,
    output logic [CW-1:0]       count,
    output logic                overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic            byte_sel_q, byte_sel_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      hold_lo_q, hold_lo_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     mem_q [DEPTH];

    logic            full;
    logic            push;
    logic            pop;
    logic            baud_done;
    logic [15:0]     head;

    // Fullness uses the pre-pop count, so a push racing a pop out of a full FIFO is dropped.
    assign full      = (count_q == CW'(DEPTH));
    assign pop       = (state_q == IDLE) && (count_q != '0);
    assign push      = core.out_en && !full;
    assign baud_done = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
        if (core.out_en && full) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= core.out_data;
    end

    // The high byte goes straight into the shifter at pop; only the low byte needs holding.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q + 1'b1;
        bit_d      = bit_q;
        byte_sel_d = byte_sel_q;
        shift_d    = shift_q;
        hold_lo_d  = hold_lo_q;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (pop) begin
                    hold_lo_d  = head[7:0];
                    shift_d    = head[15:8];
                    byte_sel_d = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (!byte_sel_q) begin
                        shift_d    = hold_lo_q;
                        byte_sel_d = 1'b1;
                        state_d    = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d != IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_sel_q <= 1'b0;
            shift_q    <= '0;
            hold_lo_q  <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_sel_q <= byte_sel_d;
            shift_q    <= shift_d;
            hold_lo_q  <= hold_lo_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign tx             = tx_q;
    assign busy           = busy_q;
    assign count          = count_q;
    assign overflow       = overflow_q;
    assign core.out_stall = full;
endmodule

// File: doc/out_port_uart_tx.md
Name: out_port_uart_tx

Overview:
- Responder for the OUT instruction: accepts 16-bit words the core emits when the decoder asserts out_en.
- Buffers the words in a small FIFO and serialises each word onto a UART TX line as two 8N1 bytes.
- Sits between the core datapath (out_en, OUT operand) and the board pin. Back-pressures the core with out_stall when the FIFO is full.

Parameters:
DEPTH, 8, FIFO depth in 16-bit words; must be a power of 2, at least 2
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be at least 2
CW, $clog2(DEPTH)+1, width of the occupancy count (derived; not overridden)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
out_en  in  1  OUT instruction executes this cycle; push request
out_data  in  16  word to output; sampled when out_en=1
out_stall  out  1  FIFO full; the core must hold the OUT instruction
tx  out  1  UART serial line; idles high
busy  out  1  serialiser is not in IDLE
count  out  CW  FIFO occupancy, 0..DEPTH
overflow  out  1  sticky flag: a push was attempted while full

Behaviour:
- Reset values, asynchronous, while reset=1:
  - tx=1, busy=0, count=0, overflow=0, out_stall=0.
  - FSM=IDLE, FIFO pointers=0, baud counter=0.
- Reset mid-frame aborts the frame immediately, with tx forced to 1, and discards all FIFO contents.
- FIFO:
  - Circular buffer, with read/write pointers wrapping modulo DEPTH.
  - out_stall = (count==DEPTH), decoded from the registered count, with no combinational path from out_en.
  - Push: when out_en=1 and count<DEPTH, out_data is written at the rising edge.
  - Push when full (out_en=1, count==DEPTH): the word is dropped, overflow is set to 1 and stays 1 until reset, and count is unchanged.
  - Full-flag ordering: fullness is judged on the count before any pop in the same cycle. A push in the same cycle as a pop from a full FIFO is still rejected and counts as overflow.
  - Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- Serialiser FSM, states IDLE, START, DATA, STOP, with byte_sel: 0 = high byte, 1 = low byte.
  - IDLE:
    - If count>0 at an edge: pop the head word into a 16-bit hold register, load shifter = hold[15:8], set byte_sel=0, go to START, and set tx=0 at that same edge.
    - Otherwise remain in IDLE with tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA:
    - tx = shifter[0], LSB first.
    - Each bit lasts CLKS_PER_BIT cycles, then the shifter shifts right.
    - After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then:
    - If byte_sel=0: load shifter = hold[7:0], set byte_sel=1, go to START; tx falls at that edge.
    - If byte_sel=1: go to IDLE.
- The baud counter counts 0..CLKS_PER_BIT-1 and reloads to 0 on every state or bit change.
- Timing:
  - The high byte is always sent before the low byte.
  - There are exactly 10*CLKS_PER_BIT cycles per byte, with no gap between the two bytes of a word.
  - At least one IDLE cycle (tx=1) separates consecutive words.
- Latency: a push accepted at edge E0 into an empty FIFO while in IDLE is popped at edge E1, and tx=0 from E1.
- busy = (state != IDLE), registered.
- tx is driven from a register, with no glitches.

Test Plan:
- Reset then idle: assert reset asynchronously mid-cycle -> tx=1, count=0, busy=0, overflow=0 immediately. Hold 100 cycles -> outputs unchanged.
- Single word, CLKS_PER_BIT=4: push 0x41A5 -> tx low 1 cycle after the push edge.
  - Bits (4 cycles each): 0,1,0,0,0,0,0,1,0,1 then 0,1,0,1,0,0,1,0,1,1.
  - Total 80 cycles, then busy=0.
- Back-to-back: push 0x0001, 0x8000, 0xFFFF on consecutive cycles -> count goes 1,1,2 as the first word pops at the second edge.
  - The three words are sent in order, each followed by exactly 1 idle cycle.
  - count=0 at the end.
- Full/overflow, DEPTH=4: push 6 words on consecutive cycles while the first frame runs.
  - The first word pops immediately, and 4 more words are buffered.
  - Once count=4, out_stall=1 and the 6th push is dropped with overflow=1.
  - 5 words are transmitted; overflow stays 1.
- Pointer wrap: push and drain 3*DEPTH+1 words with distinct values 0x1000+i -> all received in order with no duplicates; count returns to 0.
- Reset mid-frame: assert reset during DATA bit 3 of the low byte with 2 words queued -> tx=1 at once and count=0. After release, no further bytes are sent.
